// File: rtl/seg7_reader_if.sv
// Result channel of seg7_reader: decoded digit/err with a valid/ready handshake
// and the sticky overrun flag.
interface seg7_reader_if;
    logic [3:0] digit;
    logic       err;
    logic       valid;
    logic       ready;
    logic       overrun;

    modport master (output digit, output err, output valid, output overrun, input ready);
    modport slave  (input digit, input err, input valid, input overrun, output ready);
endinterface

// File: rtl/seg7_reader.sv
// seg7_reader: synchronises, debounces and decodes an active-low 7-segment bus.
// Define SEG7_READER_HEX_EN to also decode the hex glyphs A..F to values 10..15.
module seg7_reader #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       seg_in,
    seg7_reader_if.master    bus
);
    localparam int          CW       = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_PRE = CW'(STABLE_CYCLES - 1);
    localparam logic [6:0]  BLANK    = 7'h7F;

    typedef enum logic [0:0] {EMPTY = 1'b0, FULL = 1'b1} slot_e;

    // Returns {err, digit}; unknown glyphs decode to err=1, digit=0.
    function automatic logic [4:0] decode_seg(input logic [6:0] pat);
        logic [4:0] r;
        case (pat)
            7'h40:   r = 5'h00;
            7'h79:   r = 5'h01;
            7'h24:   r = 5'h02;
            7'h30:   r = 5'h03;
            7'h19:   r = 5'h04;
            7'h12:   r = 5'h05;
            7'h02:   r = 5'h06;
            7'h78:   r = 5'h07;
            7'h00:   r = 5'h08;
            7'h10:   r = 5'h09;
`ifdef SEG7_READER_HEX_EN
            7'h08:   r = 5'h0A;
            7'h03:   r = 5'h0B;
            7'h46:   r = 5'h0C;
            7'h21:   r = 5'h0D;
            7'h06:   r = 5'h0E;
            7'h0E:   r = 5'h0F;
`endif
            default: r = 5'h10;
        endcase
        return r;
    endfunction

    logic [6:0]    sync1_q, sync1_d;
    logic [6:0]    sync2_q, sync2_d;
    logic [6:0]    prev_q,  prev_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [6:0]    last_q,  last_d;
    slot_e         state_q, state_d;
    logic [3:0]    digit_q, digit_d;
    logic          err_q,   err_d;
    logic          overrun_q, overrun_d;

    logic          same_s;
    logic          accept_s;
    logic          blank_s;
    logic          result_s;
    logic [4:0]    dec_s;

    // Synchroniser, stability counter and last-emitted tracking.
    always_comb begin
        sync1_d  = seg_in;
        sync2_d  = sync1_q;
        prev_d   = sync2_q;
        same_s   = (sync2_q == prev_q);
        blank_s  = (sync2_q == BLANK);
        // Acceptance fires on the single sample where the count reaches its ceiling.
        accept_s = same_s && (cnt_q == CNT_PRE);
        result_s = accept_s && !blank_s && (sync2_q != last_q);
        dec_s    = decode_seg(sync2_q);

        if (!same_s) begin
            cnt_d = {CW{1'b0}};
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end

        if (accept_s && blank_s) begin
            last_d = BLANK;
        end else if (result_s) begin
            last_d = sync2_q;
        end else begin
            last_d = last_q;
        end
    end

    // Output slot next-state and data.
    always_comb begin
        state_d   = state_q;
        digit_d   = digit_q;
        err_d     = err_q;
        overrun_d = overrun_q;
        case (state_q)
            EMPTY: begin
                if (result_s) begin
                    state_d = FULL;
                    digit_d = dec_s[3:0];
                    err_d   = dec_s[4];
                end else begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (bus.ready) begin
                    if (result_s) begin
                        state_d = FULL;
                        digit_d = dec_s[3:0];
                        err_d   = dec_s[4];
                    end else begin
                        state_d = EMPTY;
                    end
                end else if (result_s) begin
                    overrun_d = 1'b1;
                end else begin
                    state_d = FULL;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= BLANK;
            sync2_q   <= BLANK;
            prev_q    <= BLANK;
            cnt_q     <= {CW{1'b0}};
            last_q    <= BLANK;
            state_q   <= EMPTY;
            digit_q   <= 4'h0;
            err_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            state_q   <= state_d;
            digit_q   <= digit_d;
            err_q     <= err_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.valid   = (state_q == FULL);
    assign bus.digit   = digit_q;
    assign bus.err     = err_q;
    assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_seg7_reader.sv
// Directed self-checking bench for seg7_reader (STABLE_CYCLES=4).
module tb_seg7_reader;
    logic       clk;
    logic       rst;
    logic [6:0] seg_in;
    int         n_total;
    int         n_pass;
    int         res_cnt;
    logic [3:0] last_digit;
    logic       last_err;

    seg7_reader_if bus ();

    seg7_reader #(.STABLE_CYCLES(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .seg_in (seg_in),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs n cycles, sampling 1 time unit after each edge; counts results taken by the consumer.
    task automatic run(input int n);
        res_cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (bus.valid === 1'b1 && bus.ready === 1'b1) begin
                res_cnt++;
                last_digit = bus.digit;
                last_err   = bus.err;
            end
        end
    endtask

    initial begin
        n_total    = 0;
        n_pass     = 0;
        res_cnt    = 0;
        last_digit = 4'h0;
        last_err   = 1'b0;
        rst        = 1'b1;
        seg_in     = 7'h7F;
        bus.ready  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid",   32'(bus.valid),   32'h0);
        chk("rst_digit",   32'(bus.digit),   32'h0);
        chk("rst_err",     32'(bus.err),     32'h0);
        chk("rst_overrun", 32'(bus.overrun), 32'h0);

        // Steady digit 3: latency is edge 6 counted from the first sampling edge 0
        rst       = 1'b0;
        seg_in    = 7'h30;
        bus.ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("lat_early", 32'(bus.valid), 32'h0);
        @(posedge clk);
        #1;
        chk("lat_valid", 32'(bus.valid), 32'h1);
        chk("lat_digit", 32'(bus.digit), 32'h3);
        chk("lat_err",   32'(bus.err),   32'h0);
        run(20);
        chk("steady_no_repeat", 32'(res_cnt), 32'h0);

        // Glitch rejection: 1 for three cycles, then 0 held
        seg_in = 7'h79;
        repeat (3) @(posedge clk);
        #1;
        seg_in = 7'h40;
        run(20);
        chk("glitch_count", 32'(res_cnt),    32'h1);
        chk("glitch_digit", 32'(last_digit), 32'h0);

        // Illegal glyph
        seg_in = 7'h7E;
        run(20);
        chk("illegal_count", 32'(res_cnt),    32'h1);
        chk("illegal_err",   32'(last_err),   32'h1);
        chk("illegal_digit", 32'(last_digit), 32'h0);

        // Backpressure: 2 held, 9 dropped
        bus.ready = 1'b0;
        seg_in    = 7'h24;
        run(15);
        chk("bp_valid1", 32'(bus.valid), 32'h1);
        chk("bp_digit1", 32'(bus.digit), 32'h2);
        seg_in = 7'h10;
        run(15);
        chk("bp_valid2",  32'(bus.valid),   32'h1);
        chk("bp_digit2",  32'(bus.digit),   32'h2);
        chk("bp_overrun", 32'(bus.overrun), 32'h1);
        bus.ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_drain_valid", 32'(bus.valid), 32'h0);
        run(20);
        chk("bp_no_nine",      32'(res_cnt),     32'h0);
        chk("bp_overrun_stk",  32'(bus.overrun), 32'h1);

        // Blank re-arm: 5, blank, 5
        res_cnt = 0;
        seg_in  = 7'h12;
        run(10);
        begin
            int acc;
            acc    = res_cnt;
            seg_in = 7'h7F;
            run(10);
            acc    = acc + res_cnt;
            chk("blank_no_result", 32'(res_cnt), 32'h0);
            seg_in = 7'h12;
            run(10);
            acc    = acc + res_cnt;
            run(10);
            acc    = acc + res_cnt;
            chk("rearm_count", 32'(acc),        32'h2);
            chk("rearm_digit", 32'(last_digit), 32'h5);
        end

        // Hex glyph A
        seg_in = 7'h08;
        run(20);
        chk("hex_count", 32'(res_cnt), 32'h1);
`ifdef SEG7_READER_HEX_EN
        chk("hex_digit", 32'(last_digit), 32'hA);
        chk("hex_err",   32'(last_err),   32'h0);
`else
        chk("hex_digit", 32'(last_digit), 32'h0);
        chk("hex_err",   32'(last_err),   32'h1);
`endif

        // Reset mid-operation discards the held result and re-emits after release
        bus.ready = 1'b0;
        seg_in    = 7'h19;
        run(15);
        chk("mr_held_valid", 32'(bus.valid), 32'h1);
        chk("mr_held_digit", 32'(bus.digit), 32'h4);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("mr_rst_valid",   32'(bus.valid),   32'h0);
        chk("mr_rst_overrun", 32'(bus.overrun), 32'h0);
        rst       = 1'b0;
        bus.ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("mr_early", 32'(bus.valid), 32'h0);
        @(posedge clk);
        #1;
        chk("mr_valid", 32'(bus.valid), 32'h1);
        chk("mr_digit", 32'(bus.digit), 32'h4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
